next_pc_predictor: RTL and testbench
====================================

Name: next_pc_predictor

Overview:
- Fetch-stage next-PC unit for the 5-stage MIPS pipeline. Owns the PC register and predicts the next fetch address each cycle.
- Uses a parametrised direct-mapped branch target buffer (BTB), 2-bit saturating direction counters and a return address stack (RAS).
- EX-stage resolution trains the predictor. EX supplies the actual target, from its branch/jump/jump-register calculation, plus a redirect on mispredict.

Parameters:
- ADDR_WIDTH, 32, PC/target width in bits.
- BTB_ENTRIES, 16, BTB entries; power of two, at least 2.
- RAS_DEPTH, 4, return address stack entries, at least 1.
- RESET_PC, 32'h0040_0000, PC value after reset.

Ports:
- CLOCK  in  1  single clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- Stall_IN  in  1  hold PC and RAS (decode/hazard stall).
- FetchAddress_OUT  out  ADDR_WIDTH  current PC.
- PredictedTaken_OUT  out  1  predictor chooses a non-sequential next PC.
- PredictedTarget_OUT  out  ADDR_WIDTH  predicted next PC (target, or PC+4 when not taken).
- Update_IN  in  1  a control-flow instruction resolved in EX this cycle.
- UpdateAddress_IN  in  ADDR_WIDTH  PC of the resolved instruction.
- UpdateTaken_IN  in  1  actual direction (jumps always 1).
- UpdateTarget_IN  in  ADDR_WIDTH  actual target address.
- UpdateKind_IN  in  2  00 branch, 01 jump, 10 call (jal/jalr), 11 return (jr $ra).
- Mispredict_IN  in  1  redirect fetch.
- RedirectAddress_IN  in  ADDR_WIDTH  correct next PC.

Behaviour:
- Reset (async):
  - PC = RESET_PC.
  - All BTB valid bits = 0; all counters = 2'b01.
  - RAS count = 0, RAS pointer = 0.
  - Reset output values: PredictedTaken_OUT = 0, PredictedTarget_OUT = RESET_PC+4.
  - Reset asserted mid-operation discards all state immediately.
- Indexing:
  - IDXW = log2(BTB_ENTRIES).
  - index = PC[IDXW+1:2].
  - tag = PC[ADDR_WIDTH-1:IDXW+2].
  - The same fields are taken from UpdateAddress_IN for updates.
- Lookup (combinational on current PC, zero latency):
  - hit = valid & tag match.
  - taken = hit & (kind != branch | counter[1]).
  - target = RAS top when kind is return and RAS count > 0; otherwise the stored target.
  - Not taken: PredictedTarget_OUT = PC+4, modulo 2^ADDR_WIDTH.
- PC update, priority order:
  1. Mispredict_IN: PC <= RedirectAddress_IN. This wins over Stall_IN.
  2. Stall_IN: hold.
  3. Otherwise: PC <= PredictedTarget_OUT.
- BTB update, on Update_IN at the clock edge:
  - Taken, with matching valid entry: write target and kind; counter saturating increment (max 11).
  - Taken, miss or tag mismatch: allocate/replace the entry; write tag, target and kind; counter = 10.
  - Not taken, matching entry: counter saturating decrement (min 00). Entry is retained.
  - Not taken, miss: no change.
- RAS operation (only in advancing cycles: no stall, no mispredict):
  - Predicted call hit: push PC+4.
  - Predicted return hit with count > 0: pop.
  - Push when full: circular overwrite of the oldest entry; count stays at RAS_DEPTH.
  - Pop when empty: no pop; the stored BTB target is used.
- RAS is not repaired on mispredict. It is speculative by design, and this is documented.
- Simultaneous events:
  - Update_IN and lookup on the same index: lookup sees pre-update contents; the update is visible next cycle.
  - Update_IN and Mispredict_IN in the same cycle: both take effect.
  - Update_IN during Stall_IN: the update still applies.
- Latency: prediction is available in the same cycle as FetchAddress_OUT; training takes effect one cycle after the update.

Decomposition:
- Shared package npc_pkg:
  - kind encoding constants: KIND_BRANCH, KIND_JUMP, KIND_CALL, KIND_RETURN.
  - counter constants: CTR_SNT=00, CTR_WNT=01, CTR_WT=10, CTR_ST=11.
  - saturating increment/decrement functions.
- Sub-module return_address_stack:
  - Parameters: RAS_DEPTH, ADDR_WIDTH.
  - Ports: push, pop, push data, top, empty.
  - Behaviour: circular overwrite on full.
- The BTB arrays and PC register stay in next_pc_predictor.

Test Plan:
- Reset with RESET_PC=0x00400000, no updates → FetchAddress 0x00400000, 0x00400004, 0x00400008 on successive cycles; PredictedTaken_OUT = 0 throughout.
- Branch training:
  - Update taken at 0x00400010, target 0x00400100, kind 00 → next fetch of 0x00400010 gives PredictedTaken=1 and next PC 0x00400100.
  - Then two not-taken updates at 0x00400010 → counter 00; the next fetch there predicts 0x00400014.
- Stall_IN=1 and Mispredict_IN=1 with RedirectAddress 0x00400200 in the same cycle → PC = 0x00400200 next cycle. Stall alone holds the PC for 3 cycles.
- Call/return:
  - Train call at 0x00400100 (target 0x00400400, kind 10) and return at 0x00400408 (target 0xDEADBEE0, kind 11).
  - Fetch path 0x00400100 → 0x00400400..0x00400408 → PredictedTarget 0x00400104.
- RAS overflow with RAS_DEPTH=4:
  - Five predicted calls push A..E.
  - Five predicted returns yield E, D, C, B, then the stored BTB target (RAS empty).
- Aliasing with BTB_ENTRIES=16:
  - Taken update at 0x00400040, then taken update at 0x00400080 (same index 0, different tag).
  - Fetch 0x00400040 → miss, PredictedTarget 0x00400044.

Source files
------------

// File: rtl/npc_pkg.sv
// ---------------------------------------------------------------------------
// npc_pkg
// Shared definitions for the fetch-stage next-PC predictor:
//   - control-flow kind encoding as reported by EX on UpdateKind_IN
//   - 2-bit direction counter states
//   - saturating counter helpers
// ---------------------------------------------------------------------------
package npc_pkg;

    localparam logic [1:0] KIND_BRANCH = 2'b00;
    localparam logic [1:0] KIND_JUMP   = 2'b01;
    localparam logic [1:0] KIND_CALL   = 2'b10;
    localparam logic [1:0] KIND_RETURN = 2'b11;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    function automatic logic [1:0] satInc(input logic [1:0] ctr);
        return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    endfunction

    function automatic logic [1:0] satDec(input logic [1:0] ctr);
        return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/next_pc_predictor_ras.sv
// ---------------------------------------------------------------------------
// return_address_stack
// Circular return address stack. A push when full overwrites the oldest
// entry and the occupancy stays at RAS_DEPTH. A pop when empty is ignored.
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   push         : store pushData as the new top
//   pop          : discard the top entry (ignored when empty)
//   pushData     : return address to push
//   top          : current top entry (meaningless while empty)
//   empty        : no entries held
// ---------------------------------------------------------------------------
module return_address_stack #(
    parameter int RAS_DEPTH  = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] pushData,
    output logic [ADDR_WIDTH-1:0] top,
    output logic                  empty
);

    localparam int PTRW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNTW = $clog2(RAS_DEPTH + 1);
    localparam logic [PTRW-1:0] LAST_SLOT = PTRW'(RAS_DEPTH - 1);
    localparam logic [CNTW-1:0] FULL_COUNT = CNTW'(RAS_DEPTH);

    logic [ADDR_WIDTH-1:0] stackMem [RAS_DEPTH];
    logic [PTRW-1:0]       writePtr;   // next free slot; top is the slot below
    logic [CNTW-1:0]       count;
    logic [PTRW-1:0]       ptrInc;
    logic [PTRW-1:0]       ptrDec;

    // Explicit wrap so non-power-of-two depths stay circular.
    assign ptrInc = (writePtr == LAST_SLOT) ? '0 : writePtr + 1'b1;
    assign ptrDec = (writePtr == '0) ? LAST_SLOT : writePtr - 1'b1;

    assign top   = stackMem[ptrDec];
    assign empty = (count == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            writePtr <= '0;
            count    <= '0;
        end else if (push) begin
            writePtr <= ptrInc;
            if (count != FULL_COUNT) begin
                count <= count + 1'b1;
            end
        end else if (pop && !empty) begin
            writePtr <= ptrDec;
            count    <= count - 1'b1;
        end
    end

    // Storage needs no reset: top is only consumed while not empty.
    always_ff @(posedge clock) begin
        if (push) begin
            stackMem[writePtr] <= pushData;
        end
    end

endmodule

// File: rtl/next_pc_predictor.sv
// ---------------------------------------------------------------------------
// next_pc_predictor
// Fetch-stage next-PC unit. Holds the PC and predicts the next fetch address
// with a direct-mapped BTB (tag, target, kind, 2-bit counter per entry) and a
// return address stack. EX trains the BTB and redirects fetch on mispredict.
// The RAS is speculative: pushes/pops follow predictions and it is not
// repaired when EX redirects.
// Ports:
//   CLOCK, RESET        : rising-edge clock, asynchronous active-high reset
//   Stall_IN            : hold PC and RAS
//   FetchAddress_OUT    : current PC
//   PredictedTaken_OUT  : next PC is non-sequential
//   PredictedTarget_OUT : predicted next PC
//   Update_IN, UpdateAddress_IN, UpdateTaken_IN, UpdateTarget_IN,
//   UpdateKind_IN       : EX resolution of one control-flow instruction
//   Mispredict_IN, RedirectAddress_IN : fetch redirect (beats Stall_IN)
// ---------------------------------------------------------------------------
module next_pc_predictor
    import npc_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    BTB_ENTRIES = 16,
    parameter int                    RAS_DEPTH   = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 'h0040_0000
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  Stall_IN,
    output logic [ADDR_WIDTH-1:0] FetchAddress_OUT,
    output logic                  PredictedTaken_OUT,
    output logic [ADDR_WIDTH-1:0] PredictedTarget_OUT,
    input  logic                  Update_IN,
    input  logic [ADDR_WIDTH-1:0] UpdateAddress_IN,
    input  logic                  UpdateTaken_IN,
    input  logic [ADDR_WIDTH-1:0] UpdateTarget_IN,
    input  logic [1:0]            UpdateKind_IN,
    input  logic                  Mispredict_IN,
    input  logic [ADDR_WIDTH-1:0] RedirectAddress_IN
);

    localparam int IDXW = $clog2(BTB_ENTRIES);
    localparam int TAGW = ADDR_WIDTH - IDXW - 2;

    logic [ADDR_WIDTH-1:0] pc;

    logic                  btbValid  [BTB_ENTRIES];
    logic [TAGW-1:0]       btbTag    [BTB_ENTRIES];
    logic [ADDR_WIDTH-1:0] btbTarget [BTB_ENTRIES];
    logic [1:0]            btbKind   [BTB_ENTRIES];
    logic [1:0]            btbCtr    [BTB_ENTRIES];

    logic [IDXW-1:0]       lookupIdx;
    logic [TAGW-1:0]       lookupTag;
    logic [IDXW-1:0]       updIdx;
    logic [TAGW-1:0]       updTag;
    logic                  lookupHit;
    logic                  updHit;
    logic [1:0]            lookupKind;
    logic [ADDR_WIDTH-1:0] pcPlus4;
    logic                  advance;
    logic                  rasPush;
    logic                  rasPop;
    logic [ADDR_WIDTH-1:0] rasTop;
    logic                  rasEmpty;

    assign lookupIdx = pc[IDXW+1:2];
    assign lookupTag = pc[ADDR_WIDTH-1:IDXW+2];
    assign updIdx    = UpdateAddress_IN[IDXW+1:2];
    assign updTag    = UpdateAddress_IN[ADDR_WIDTH-1:IDXW+2];

    assign lookupHit  = btbValid[lookupIdx] && (btbTag[lookupIdx] == lookupTag);
    assign updHit     = btbValid[updIdx] && (btbTag[updIdx] == updTag);
    assign lookupKind = btbKind[lookupIdx];
    assign pcPlus4    = pc + ADDR_WIDTH'(4);

    // Lookup always sees the BTB as it was before this cycle's update.
    always_comb begin
        PredictedTaken_OUT  = 1'b0;
        PredictedTarget_OUT = pcPlus4;
        if (lookupHit && (lookupKind != KIND_BRANCH || btbCtr[lookupIdx][1])) begin
            PredictedTaken_OUT = 1'b1;
            if (lookupKind == KIND_RETURN && !rasEmpty) begin
                PredictedTarget_OUT = rasTop;
            end else begin
                PredictedTarget_OUT = btbTarget[lookupIdx];
            end
        end
    end

    assign FetchAddress_OUT = pc;

    // The RAS only moves when the fetch actually advances on its prediction.
    assign advance = !Stall_IN && !Mispredict_IN;
    assign rasPush = advance && PredictedTaken_OUT && (lookupKind == KIND_CALL);
    assign rasPop  = advance && PredictedTaken_OUT && (lookupKind == KIND_RETURN);

    return_address_stack #(
        .RAS_DEPTH  (RAS_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ras (
        .clock    (CLOCK),
        .reset    (RESET),
        .push     (rasPush),
        .pop      (rasPop),
        .pushData (pcPlus4),
        .top      (rasTop),
        .empty    (rasEmpty)
    );

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            pc <= RESET_PC;
        end else if (Mispredict_IN) begin
            pc <= RedirectAddress_IN;
        end else if (!Stall_IN) begin
            pc <= PredictedTarget_OUT;
        end
    end

    // Valid bits and counters: the only BTB state that reset must clear.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btbValid[i] <= 1'b0;
                btbCtr[i]   <= CTR_WNT;
            end
        end else if (Update_IN) begin
            if (UpdateTaken_IN) begin
                btbValid[updIdx] <= 1'b1;
                btbCtr[updIdx]   <= updHit ? satInc(btbCtr[updIdx]) : CTR_WT;
            end else if (updHit) begin
                btbCtr[updIdx] <= satDec(btbCtr[updIdx]);
            end
        end
    end

    // Tag/target/kind are written on every taken update (hit or allocate).
    always_ff @(posedge CLOCK) begin
        if (Update_IN && UpdateTaken_IN) begin
            btbTag[updIdx]    <= updTag;
            btbTarget[updIdx] <= UpdateTarget_IN;
            btbKind[updIdx]   <= UpdateKind_IN;
        end
    end

endmodule

// File: tb/tb_next_pc_predictor.sv
module tb_next_pc_predictor;

    localparam int          NE  = 16;
    localparam int          RD  = 4;
    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        Stall_IN;
    logic [31:0] FetchAddress_OUT;
    logic        PredictedTaken_OUT;
    logic [31:0] PredictedTarget_OUT;
    logic        Update_IN;
    logic [31:0] UpdateAddress_IN;
    logic        UpdateTaken_IN;
    logic [31:0] UpdateTarget_IN;
    logic [1:0]  UpdateKind_IN;
    logic        Mispredict_IN;
    logic [31:0] RedirectAddress_IN;

    // ---------------- clock / reset ----------------
    always #5 CLOCK = ~CLOCK;

    next_pc_predictor #(
        .ADDR_WIDTH  (32),
        .BTB_ENTRIES (NE),
        .RAS_DEPTH   (RD),
        .RESET_PC    (RPC)
    ) dut (
        .CLOCK               (CLOCK),
        .RESET               (RESET),
        .Stall_IN            (Stall_IN),
        .FetchAddress_OUT    (FetchAddress_OUT),
        .PredictedTaken_OUT  (PredictedTaken_OUT),
        .PredictedTarget_OUT (PredictedTarget_OUT),
        .Update_IN           (Update_IN),
        .UpdateAddress_IN    (UpdateAddress_IN),
        .UpdateTaken_IN      (UpdateTaken_IN),
        .UpdateTarget_IN     (UpdateTarget_IN),
        .UpdateKind_IN       (UpdateKind_IN),
        .Mispredict_IN       (Mispredict_IN),
        .RedirectAddress_IN  (RedirectAddress_IN)
    );

    int vecCount  = 0;
    int missCount = 0;

    // ---------------- reference model ----------------
    // BTB kept as per-slot records holding the full instruction address;
    // "same tag" means same address above the index bits.
    logic [31:0] mPc;
    bit          mVal  [NE];
    logic [31:0] mAddr [NE];
    logic [31:0] mTgt  [NE];
    logic [1:0]  mKind [NE];
    int          mCtr  [NE];
    logic [31:0] mRas  [$];

    function automatic int slotOf(input logic [31:0] a);
        return int'((a / 4) % NE);
    endfunction

    function automatic bit sameTag(input logic [31:0] a, input logic [31:0] b);
        return (a / (4 * NE)) == (b / (4 * NE));
    endfunction

    task automatic modelReset();
        mPc = RPC;
        for (int i = 0; i < NE; i++) begin
            mVal[i] = 0; mCtr[i] = 1; mAddr[i] = '0; mTgt[i] = '0; mKind[i] = 2'b00;
        end
        mRas.delete();
    endtask

    task automatic modelPredict(output bit tk, output logic [31:0] tg);
        int s;
        bit hit;
        s   = slotOf(mPc);
        hit = mVal[s] && sameTag(mAddr[s], mPc);
        tk  = hit && (mKind[s] != 2'b00 || mCtr[s] >= 2);
        if (!tk) tg = mPc + 32'd4;
        else if (mKind[s] == 2'b11 && mRas.size() > 0) tg = mRas[$];
        else tg = mTgt[s];
    endtask

    task automatic modelAdvance();
        bit          tk;
        logic [31:0] tg;
        int          s;
        int          u;
        bit          uhit;
        modelPredict(tk, tg);
        s = slotOf(mPc);
        if (!Stall_IN && !Mispredict_IN && tk) begin
            if (mKind[s] == 2'b10) begin
                mRas.push_back(mPc + 32'd4);
                if (mRas.size() > RD) void'(mRas.pop_front());
            end else if (mKind[s] == 2'b11 && mRas.size() > 0) begin
                void'(mRas.pop_back());
            end
        end
        if (Update_IN) begin
            u    = slotOf(UpdateAddress_IN);
            uhit = mVal[u] && sameTag(mAddr[u], UpdateAddress_IN);
            if (UpdateTaken_IN) begin
                mCtr[u]  = uhit ? ((mCtr[u] < 3) ? mCtr[u] + 1 : 3) : 2;
                mVal[u]  = 1;
                mAddr[u] = UpdateAddress_IN;
                mTgt[u]  = UpdateTarget_IN;
                mKind[u] = UpdateKind_IN;
            end else if (uhit) begin
                mCtr[u] = (mCtr[u] > 0) ? mCtr[u] - 1 : 0;
            end
        end
        if (Mispredict_IN) mPc = RedirectAddress_IN;
        else if (!Stall_IN) mPc = tg;
    endtask

    // ---------------- scoreboard ----------------
    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compareModel();
        bit          tk;
        logic [31:0] tg;
        modelPredict(tk, tg);
        checkVal("model_pc", FetchAddress_OUT, mPc);
        checkVal("model_taken", {31'b0, PredictedTaken_OUT}, {31'b0, tk});
        checkVal("model_target", PredictedTarget_OUT, tg);
    endtask

    // Called #1 after the falling edge: check, step model, cross the edge.
    task automatic advanceCycle();
        compareModel();
        modelAdvance();
        @(posedge CLOCK);
        @(negedge CLOCK);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        stall;
        logic        upd;
        logic [31:0] uAddr;
        logic        uTaken;
        logic [31:0] uTarget;
        logic [1:0]  uKind;
        logic        misp;
        logic [31:0] redir;
        logic        chk;
        logic [31:0] ePc;
        logic        eTaken;
        logic [31:0] eTarget;
    } vec_t;

    vec_t vecs[$];

    function automatic void addVec(input logic stall, input logic upd, input logic [31:0] uAddr,
                                   input logic uTaken, input logic [31:0] uTarget, input logic [1:0] uKind,
                                   input logic misp, input logic [31:0] redir, input logic chk,
                                   input logic [31:0] ePc, input logic eTaken, input logic [31:0] eTarget);
        vec_t v;
        v.stall = stall; v.upd = upd; v.uAddr = uAddr; v.uTaken = uTaken; v.uTarget = uTarget;
        v.uKind = uKind; v.misp = misp; v.redir = redir; v.chk = chk;
        v.ePc = ePc; v.eTaken = eTaken; v.eTarget = eTarget;
        vecs.push_back(v);
    endfunction

    task automatic driveIdle();
        Stall_IN = 0; Update_IN = 0; UpdateAddress_IN = '0; UpdateTaken_IN = 0;
        UpdateTarget_IN = '0; UpdateKind_IN = 2'b00; Mispredict_IN = 0; RedirectAddress_IN = '0;
    endtask

    task automatic driveRandom();
        Stall_IN           = ($urandom_range(0, 4) == 0);
        Mispredict_IN      = ($urandom_range(0, 7) == 0);
        RedirectAddress_IN = RPC + 32'(4 * $urandom_range(0, 63));
        Update_IN          = 1'($urandom_range(0, 1));
        UpdateAddress_IN   = RPC + 32'(4 * $urandom_range(0, 63));
        UpdateKind_IN      = 2'($urandom_range(0, 3));
        UpdateTaken_IN     = (UpdateKind_IN != 2'b00) ? 1'b1 : 1'($urandom_range(0, 1));
        UpdateTarget_IN    = RPC + 32'(4 * $urandom_range(0, 63));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] retExp [5];

    initial begin
        RESET = 1'b1;
        driveIdle();
        modelReset();

        // Reset / sequential fetch and branch training
        addVec(0,0,'0,0,'0,0, 0,'0, 1, 32'h00400000,0,32'h00400004);
        addVec(0,0,'0,0,'0,0, 0,'0, 1, 32'h00400004,0,32'h00400008);
        addVec(0,1,32'h00400010,1,32'h00400100,2'b00, 0,'0, 1, 32'h00400008,0,32'h0040000C);
        addVec(0,0,'0,0,'0,0, 0,'0, 1, 32'h0040000C,0,32'h00400010);
        addVec(1,1,32'h00400010,0,'0,2'b00, 0,'0, 1, 32'h00400010,1,32'h00400100);
        addVec(1,1,32'h00400010,0,'0,2'b00, 0,'0, 1, 32'h00400010,0,32'h00400014);
        // Stall alone holds for three cycles
        addVec(1,0,'0,0,'0,0, 0,'0, 1, 32'h00400010,0,32'h00400014);
        addVec(1,0,'0,0,'0,0, 0,'0, 1, 32'h00400010,0,32'h00400014);
        addVec(1,0,'0,0,'0,0, 0,'0, 1, 32'h00400010,0,32'h00400014);
        // Mispredict beats stall
        addVec(1,0,'0,0,'0,0, 1,32'h00400200, 1, 32'h00400010,0,32'h00400014);
        // Call/return training during stall, then the fetch path
        addVec(1,1,32'h00400100,1,32'h00400400,2'b10, 0,'0, 1, 32'h00400200,0,32'h00400204);
        addVec(1,1,32'h00400408,1,32'hDEADBEE0,2'b11, 0,'0, 1, 32'h00400200,0,32'h00400204);
        addVec(0,0,'0,0,'0,0, 1,32'h00400100, 1, 32'h00400200,0,32'h00400204);
        addVec(0,0,'0,0,'0,0, 0,'0, 1, 32'h00400100,1,32'h00400400);
        addVec(0,0,'0,0,'0,0, 0,'0, 1, 32'h00400400,0,32'h00400404);
        addVec(0,0,'0,0,'0,0, 0,'0, 1, 32'h00400404,0,32'h00400408);
        addVec(0,0,'0,0,'0,0, 0,'0, 1, 32'h00400408,1,32'h00400104);
        addVec(0,0,'0,0,'0,0, 0,'0, 1, 32'h00400104,0,32'h00400108);
        // RAS overflow: five calls, one return entry
        for (int i = 0; i < 5; i++)
            addVec(1,1,32'h00401000 + 32'(4*i),1,32'h00405000,2'b10, 0,'0, 0, '0,0,'0);
        addVec(1,1,32'h00402020,1,32'h00403000,2'b11, 0,'0, 0, '0,0,'0);
        for (int i = 0; i < 5; i++) begin
            addVec(0,0,'0,0,'0,0, 1,32'h00401000 + 32'(4*i), 0, '0,0,'0);
            addVec(0,0,'0,0,'0,0, 0,'0, 1, 32'h00401000 + 32'(4*i),1,32'h00405000);
        end
        retExp[0] = 32'h00401014; retExp[1] = 32'h00401010; retExp[2] = 32'h0040100C;
        retExp[3] = 32'h00401008; retExp[4] = 32'h00403000;
        for (int i = 0; i < 5; i++) begin
            addVec(0,0,'0,0,'0,0, 1,32'h00402020, 0, '0,0,'0);
            addVec(0,0,'0,0,'0,0, 0,'0, 1, 32'h00402020,1,retExp[i]);
        end
        // Aliasing on index 0
        addVec(1,1,32'h00400040,1,32'h00400500,2'b00, 0,'0, 0, '0,0,'0);
        addVec(1,1,32'h00400080,1,32'h00400600,2'b00, 0,'0, 0, '0,0,'0);
        addVec(0,0,'0,0,'0,0, 1,32'h00400040, 0, '0,0,'0);
        addVec(0,0,'0,0,'0,0, 0,'0, 1, 32'h00400040,0,32'h00400044);
        addVec(0,0,'0,0,'0,0, 0,'0, 0, '0,0,'0);

        repeat (2) @(negedge CLOCK);
        RESET = 1'b0;

        foreach (vecs[k]) begin
            Stall_IN = vecs[k].stall; Update_IN = vecs[k].upd; UpdateAddress_IN = vecs[k].uAddr;
            UpdateTaken_IN = vecs[k].uTaken; UpdateTarget_IN = vecs[k].uTarget;
            UpdateKind_IN = vecs[k].uKind; Mispredict_IN = vecs[k].misp;
            RedirectAddress_IN = vecs[k].redir;
            #1;
            if (vecs[k].chk) begin
                checkVal($sformatf("vec%0d_pc", k), FetchAddress_OUT, vecs[k].ePc);
                checkVal($sformatf("vec%0d_taken", k), {31'b0, PredictedTaken_OUT}, {31'b0, vecs[k].eTaken});
                checkVal($sformatf("vec%0d_target", k), PredictedTarget_OUT, vecs[k].eTarget);
            end
            advanceCycle();
        end

        // Asynchronous reset mid-operation: visible before any clock edge
        driveIdle();
        #1 RESET = 1'b1;
        #1;
        modelReset();
        checkVal("async_reset_pc", FetchAddress_OUT, RPC);
        checkVal("async_reset_taken", {31'b0, PredictedTaken_OUT}, 32'd0);
        checkVal("async_reset_target", PredictedTarget_OUT, RPC + 32'd4);
        @(negedge CLOCK);
        RESET = 1'b0;

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            driveRandom();
            #1;
            advanceCycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
